// File: rtl/ram_bus_arb2.sv
// Two-master to one-slave arbiter for the req/ack/resp RAM bus, with an ID FIFO routing in-order read responses.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module ram_bus_arb2 #(
    parameter int RESP_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_bi,
    input  logic [DATA_W/8-1:0] m0_be_bi,
    input  logic [DATA_W-1:0]   m0_wdata_bi,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_bo,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_bi,
    input  logic [DATA_W/8-1:0] m1_be_bi,
    input  logic [DATA_W-1:0]   m1_wdata_bi,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_bo,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_bo,
    output logic [DATA_W/8-1:0] s_be_bo,
    output logic [DATA_W-1:0]   s_wdata_bo,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_bi,
    output logic                resp_err_o
);

    localparam int              PTR_W    = $clog2(RESP_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(RESP_DEPTH);

    logic                  prio;
    logic                  gnt;
    logic [RESP_DEPTH-1:0] id_mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  can_issue;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  head_id;

    // gnt = 1 selects master 1; pointer only matters under contention
    assign gnt = m1_req_i & (~m0_req_i | prio);

    always_comb begin
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
        if (gnt) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
        end
    end

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A full FIFO still issues when a response frees a slot this cycle
    assign can_issue  = ~fifo_full | s_resp_i;
    assign s_req_o    = (m0_req_i | m1_req_i) & can_issue & ~rst_i;
    assign accept     = s_req_o & s_ack_i;
    assign m0_ack_o   = accept & ~gnt;
    assign m1_ack_o   = accept & gnt;

    assign push    = accept & ~s_we_o;
    assign pop     = s_resp_i & ~fifo_empty;
    assign head_id = id_mem[rd_ptr];

    assign m0_resp_o   = pop & ~head_id;
    assign m1_resp_o   = pop & head_id;
    assign m0_rdata_bo = s_rdata_bi;
    assign m1_rdata_bo = s_rdata_bi;

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       prio <= 1'b0;
        else if (accept) prio <= ~gnt;
    end
`else
    assign prio = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= gnt;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                      resp_err_o <= 1'b0;
        else if (s_resp_i & fifo_empty) resp_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_ram_bus_arb2.sv
// Directed bench for ram_bus_arb2: slave stub with 1-cycle auto response or manual response control.
module tb_ram_bus_arb2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_bi, m1_addr_bi, m0_wdata_bi, m1_wdata_bi;
    logic [3:0]  m0_be_bi, m1_be_bi;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o, s_ack_i, s_resp_i, resp_err_o;
    logic [31:0] s_addr_bo, s_wdata_bo, s_rdata_bi;
    logic [3:0]  s_be_bo;

    logic        stub_auto, resp_man, resp_q;
    logic [31:0] rdata_man, rdata_q;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ram_bus_arb2 #(.RESP_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
        .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
        .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
        .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
        .resp_err_o(resp_err_o)
    );

    // Slave stub: always accepts; in auto mode answers reads one cycle later
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    assign s_ack_i    = s_req_o;
    assign s_resp_i   = resp_q | resp_man;
    assign s_rdata_bi = resp_man ? rdata_man : rdata_q;

    always @(posedge clk_i) begin
        resp_q  <= stub_auto & s_req_o & s_ack_i & ~s_we_o;
        rdata_q <= mem_word(s_addr_bo);
    end

    task automatic idle_masters();
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_be_bi = 4'hF; m0_wdata_bi = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_be_bi = 4'hF; m1_wdata_bi = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        idle_masters();
        resp_man = 0;
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; stub_auto = 1; resp_man = 0; rdata_man = 0;
        idle_masters();
        m0_req_i = 1;
        @(negedge clk_i); #1;
        checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rst_s_req got %b want 0", s_req_o); end
        checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err_o); end
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL rst_resp got %b want 00", {m0_resp_o, m1_resp_o}); end
        m0_req_i = 0;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        m0_req_i = 1; m0_addr_bi = 32'h10; #1;
        checks++; if ({s_req_o, m0_ack_o, m1_ack_o} !== 3'b110) begin errors++; $display("FAIL sr_ack got %b want 110", {s_req_o, m0_ack_o, m1_ack_o}); end
        checks++; if (s_addr_bo !== 32'h10) begin errors++; $display("FAIL sr_addr got %h want 00000010", s_addr_bo); end
        @(negedge clk_i);
        m0_req_i = 0; #1;
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b10) begin errors++; $display("FAIL sr_resp got %b want 10", {m0_resp_o, m1_resp_o}); end
        checks++; if (m0_rdata_bo !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got %h want deadbeef", m0_rdata_bo); end
        @(negedge clk_i); #1;
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL sr_resp_after got %b want 00", {m0_resp_o, m1_resp_o}); end
    endtask

    task automatic test_contention();
        logic        g [0:8];
        int          n0 = 0, n1 = 0;
        logic        exp_o;
        for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_RR_EN
            g[i] = i[0];
`else
            g[i] = 1'b0;
`endif
        end
        g[8] = 1'b1;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk_i);
            m0_req_i = (i < 8); m0_addr_bi = 32'h100;
            m1_req_i = (i < 9); m1_addr_bi = 32'h200;
            #1;
            if (i < 9) begin
                if (m0_ack_o) n0++;
                if (m1_ack_o) n1++;
                checks++;
                if ({m0_ack_o, m1_ack_o} !== {~g[i], g[i]})
                    begin errors++; $display("FAIL ct_ack cyc %0d got %b want %b", i, {m0_ack_o, m1_ack_o}, {~g[i], g[i]}); end
            end
            if (i > 0) begin
                exp_o = g[i-1];
                checks++;
                if ({m0_resp_o, m1_resp_o} !== {~exp_o, exp_o} || s_rdata_bi !== (exp_o ? 32'hC0DE0200 : 32'hC0DE0100))
                    begin errors++; $display("FAIL ct_resp cyc %0d got %b/%h want %b", i, {m0_resp_o, m1_resp_o}, s_rdata_bi, {~exp_o, exp_o}); end
            end
        end
`ifdef RAM_ARB_RR_EN
        checks++; if (n0 != 4 || n1 != 5) begin errors++; $display("FAIL ct_counts got %0d/%0d want 4/5", n0, n1); end
`else
        checks++; if (n0 != 8 || n1 != 1) begin errors++; $display("FAIL ct_counts got %0d/%0d want 8/1", n0, n1); end
`endif
        idle_masters();
    endtask

    task automatic test_write_and_full();
        pulse_reset();
        stub_auto = 0;
        m0_addr_bi = 32'h10;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_i);
            m0_req_i = 1; #1;
            checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL fl_rd_ack %0d got %b want 1", i, m0_ack_o); end
        end
        @(negedge clk_i);
        m0_req_i = 0;
        m1_req_i = 1; m1_we_i = 1; m1_be_bi = 4'h3; m1_wdata_bi = 32'h1234; #1;
        checks++;
        if ({s_we_o, s_be_bo, s_wdata_bo, m1_ack_o, m0_ack_o} !== {1'b1, 4'h3, 32'h1234, 1'b1, 1'b0})
            begin errors++; $display("FAIL wr_bus got we=%b be=%h wd=%h ack1=%b ack0=%b want 1/3/00001234/1/0", s_we_o, s_be_bo, s_wdata_bo, m1_ack_o, m0_ack_o); end
        @(negedge clk_i);
        m1_req_i = 0; m1_we_i = 0; m0_req_i = 1; #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL fl_4th_ack got %b want 1", m0_ack_o); end
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL wr_no_resp got %b want 00", {m0_resp_o, m1_resp_o}); end
        @(negedge clk_i); #1;
        checks++; if ({s_req_o, m0_ack_o} !== 2'b00) begin errors++; $display("FAIL fl_block got %b want 00", {s_req_o, m0_ack_o}); end
        @(negedge clk_i);
        resp_man = 1; rdata_man = 32'h11111111; #1;
        checks++;
        if ({s_req_o, m0_ack_o, m0_resp_o, m1_resp_o} !== 4'b1110 || m0_rdata_bo !== 32'h11111111)
            begin errors++; $display("FAIL fl_pushpop got %b/%h want 1110/11111111", {s_req_o, m0_ack_o, m0_resp_o, m1_resp_o}, m0_rdata_bo); end
        @(negedge clk_i);
        resp_man = 0; #1;
        checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL fl_still_full got %b want 0", s_req_o); end
        m0_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            resp_man = 1; #1;
            checks++; if ({m0_resp_o, m1_resp_o} !== 2'b10) begin errors++; $display("FAIL fl_drain %0d got %b want 10", i, {m0_resp_o, m1_resp_o}); end
        end
    endtask

    task automatic test_spurious();
        @(negedge clk_i);
        resp_man = 1; #1;
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL sp_resp got %b want 00", {m0_resp_o, m1_resp_o}); end
        checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL sp_err_pre got %b want 0", resp_err_o); end
        @(negedge clk_i);
        resp_man = 0; #1;
        checks++; if (resp_err_o !== 1'b1) begin errors++; $display("FAIL sp_err got %b want 1", resp_err_o); end
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (resp_err_o !== 1'b1) begin errors++; $display("FAIL sp_err_hold got %b want 1", resp_err_o); end
    endtask

    task automatic test_async_reset();
        stub_auto = 1;
        @(negedge clk_i);
        m0_req_i = 1; m0_addr_bi = 32'h100; m1_req_i = 1; m1_addr_bi = 32'h200;
        @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        checks++; if ({s_req_o, m0_ack_o, m1_ack_o} !== 3'b000) begin errors++; $display("FAIL ar_req got %b want 000", {s_req_o, m0_ack_o, m1_ack_o}); end
        checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL ar_err got %b want 0", resp_err_o); end
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL ar_resp got %b want 00", {m0_resp_o, m1_resp_o}); end
        @(negedge clk_i);
        idle_masters();
        rst_i = 0;
        @(negedge clk_i);
        resp_man = 1; #1;
        checks++; if ({m0_resp_o, m1_resp_o} !== 2'b00) begin errors++; $display("FAIL ar_post_resp got %b want 00", {m0_resp_o, m1_resp_o}); end
        @(negedge clk_i);
        resp_man = 0; #1;
        checks++; if (resp_err_o !== 1'b1) begin errors++; $display("FAIL ar_post_err got %b want 1", resp_err_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_and_full();
        test_spurious();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_arb2.md
Name: ram_bus_arb2

Overview:
- Two-master to one-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata RAM bus.
- Shares one port of ram_dual_memsplit, or any slave with the same protocol, between two requesters, e.g. a CPU data port and a DMA/accelerator.
- Selects a master each cycle and forwards its request combinationally.
- Records the owner of each accepted read in a small ID FIFO so each in-order slave response returns to the master that issued it.

Parameters:
- RESP_DEPTH, 4, maximum outstanding reads tracked; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  clock; everything samples on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_req_i, m1_req_i  in  1  master request.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_addr_bi, m1_addr_bi  in  ADDR_W  byte address.
- m0_be_bi, m1_be_bi  in  DATA_W/8  byte enables.
- m0_wdata_bi, m1_wdata_bi  in  DATA_W  write data.
- m0_ack_o, m1_ack_o  out  1  request accepted this cycle (combinational).
- m0_resp_o, m1_resp_o  out  1  read data valid.
- m0_rdata_bo, m1_rdata_bo  out  DATA_W  read data (both = s_rdata_bi).
- s_req_o, s_we_o  out  1  slave request / write.
- s_addr_bo  out  ADDR_W  slave address.
- s_be_bo  out  DATA_W/8  slave byte enables.
- s_wdata_bo  out  DATA_W  slave write data.
- s_ack_i  in  1  slave accepted (may depend combinationally on s_req_o).
- s_resp_i  in  1  slave read response, in order.
- s_rdata_bi  in  DATA_W  slave read data.
- resp_err_o  out  1  sticky: response arrived with no outstanding read.

Behaviour:
- Reset is asynchronous and active-high (rst_i, clock clk_i). During/after reset:
  - priority pointer = master 0
  - ID FIFO empty, count = 0
  - resp_err_o = 0
  - m*_resp_o = 0
  - s_req_o = 0 while rst_i is high
- Grant (combinational, no state beyond the pointer):
  - Exactly one requester: it is granted.
  - Both requesting: pointer master is granted.
  - Grant is re-evaluated every cycle; no lock across cycles.
- Slave-side outputs:
  - s_req_o = (m0_req_i | m1_req_i) & can_issue.
  - can_issue = !fifo_full | s_resp_i, so a push is allowed in the same cycle as a pop when full.
  - s_we/addr/be/wdata are muxed from the granted master. With no request, they follow master 0 (don't-care).
- mN_ack_o = s_ack_i & s_req_o & grant==N. The non-granted master's ack is 0.
- Accepted transfer (s_req_o & s_ack_i):
  - Read: push granted ID into the FIFO.
  - Read or write: pointer <= other master. This applies only under RAM_ARB_RR_EN; see Optional Feature.
- Response:
  - On s_resp_i with FIFO non-empty: pop head ID. m<ID>_resp_o = 1 in that same cycle (combinational routing); the other resp is 0.
  - On s_resp_i with FIFO empty: response dropped, both resp_o = 0, resp_err_o <= 1 (held until reset).
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo RESP_DEPTH.
- Writes never occupy the FIFO and never generate resp.
- Zero added latency: a read accepted in cycle T returns to its master whenever the slave responds (cycle T+1 for ram_dual_memsplit).
- A reset mid-operation discards outstanding IDs. Responses arriving after reset are counted as spurious (resp_err_o).

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin. The pointer toggles to the non-served master after every accepted transfer, so under continuous contention grants alternate 0,1,0,1.
- Undefined: fixed priority. Master 0 always wins contention and master 1 is served only when master 0 is idle. The pointer register is removed and constant 0.

Test Plan:
- Single master 0 read of addr 0x10 (RAM word 0xDEADBEEF), ack same cycle → m0_resp_o=1 at T+1 with m0_rdata_bo=0xDEADBEEF, m1_resp_o=0.
- Both masters hold continuous reads for 8 cycles with RR_EN → acks alternate m0,m1,…, 4 each. Responses route to matching masters in order, with rdata matching the per-master addresses.
- Same as above without RR_EN → m0 acked all 8 cycles, m1 0 acks; m1 acked in the cycle m0 drops req.
- Slave stub delays responses, RESP_DEPTH=4: after 4 unanswered reads s_req_o=0 and no acks. Asserting s_resp_i on a full FIFO → new read accepted the same cycle, count stays 4.
- Master 1 write with be=4'h3, wdata=0x1234 → s_we_o=1, s_be_bo=4'h3, m1_ack_o=1, no resp, FIFO count unchanged.
- s_resp_i pulse with empty FIFO → no m*_resp_o, resp_err_o=1 and held. Assert rst_i asynchronously mid-burst → resp_err_o=0, FIFO empty, s_req_o=0 without waiting for a clock edge.
